// File: rtl/param_table_pkg.sv
// Shared types and helpers for the parameter table reverse lookup (param_table_lookup).
// Table depth, miss index, scan FSM states and the default table builder.
package param_table_pkg;

  localparam int NUM_ENTRIES = 3;
  localparam logic [1:0] MISS_IDX = 2'd3;
  localparam logic [1:0] LAST_IDX = 2'd2;

  typedef int tbl_t [NUM_ENTRIES];

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } lookup_state_t;

  function automatic tbl_t build_default_tbl(input int base, input int scale, input int derived);
    tbl_t t;
    t[0] = base;
    t[1] = scale;
    t[2] = derived;
    return t;
  endfunction

endpackage

// File: rtl/param_table_store.sv
// Holds the three table entries behind one combinational read port; constant by default,
// writable registers (reset to the parameter defaults) when PARAM_LOOKUP_WR_EN is defined.
module param_table_store
  import param_table_pkg::*;
#(
  parameter int BASE_OFFSET   = 7,
  parameter int SCALE_FACTOR  = 3,
  parameter int DERIVED_VALUE = (BASE_OFFSET + 10) * SCALE_FACTOR
) (
  input  logic        [1:0]  i_rd_idx,
  output logic signed [31:0] o_rd_data
`ifdef PARAM_LOOKUP_WR_EN
  ,
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wr_en,
  input  logic        [1:0]  i_wr_idx,
  input  logic        [31:0] i_wr_data
`endif
);

  tbl_t default_tbl;
  tbl_t tbl;

  always_comb begin
    default_tbl = build_default_tbl(BASE_OFFSET, SCALE_FACTOR, DERIVED_VALUE);
  end

`ifdef PARAM_LOOKUP_WR_EN
  tbl_t tbl_q;
  tbl_t tbl_d;

  // Index 3 has no storage behind it, so such writes are dropped.
  always_comb begin
    tbl_d = tbl_q;
    if (i_wr_en && (i_wr_idx != MISS_IDX)) begin
      tbl_d[i_wr_idx] = $signed(i_wr_data);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tbl_q <= default_tbl;
    end else begin
      tbl_q <= tbl_d;
    end
  end

  always_comb begin
    tbl = tbl_q;
  end
`else
  always_comb begin
    tbl = default_tbl;
  end
`endif

  always_comb begin
    o_rd_data = '0;
    if (i_rd_idx != MISS_IDX) begin
      o_rd_data = tbl[i_rd_idx];
    end
  end

endmodule

// File: rtl/param_table_lookup.sv
// Value -> table index search, one entry per cycle; hit at k answers k+1 edges after accept, miss after 3.
// Result held with o_valid until i_ready; no new request taken until then. Write port under PARAM_LOOKUP_WR_EN.
module param_table_lookup
  import param_table_pkg::*;
#(
  parameter int BASE_OFFSET   = 7,
  parameter int SCALE_FACTOR  = 3,
  parameter int DERIVED_VALUE = (BASE_OFFSET + 10) * SCALE_FACTOR
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic signed [31:0] i_value,
  output logic               o_valid,
  input  logic               i_ready,
  output logic        [1:0]  o_index,
  output logic               o_hit
`ifdef PARAM_LOOKUP_WR_EN
  ,
  input  logic               i_wr_en,
  input  logic        [1:0]  i_wr_idx,
  input  logic        [31:0] i_wr_data
`endif
);

  lookup_state_t      state_q, state_d;
  logic signed [31:0] value_q, value_d;
  logic        [1:0]  idx_q, idx_d;
  logic               o_ready_q, o_ready_d;
  logic               o_valid_q, o_valid_d;
  logic        [1:0]  o_index_q, o_index_d;
  logic               o_hit_q, o_hit_d;
  logic signed [31:0] rd_data;

  param_table_store #(
    .BASE_OFFSET  (BASE_OFFSET),
    .SCALE_FACTOR (SCALE_FACTOR),
    .DERIVED_VALUE(DERIVED_VALUE)
  ) u_store (
    .i_rd_idx (idx_q),
    .o_rd_data(rd_data)
`ifdef PARAM_LOOKUP_WR_EN
    ,
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wr_en  (i_wr_en),
    .i_wr_idx (i_wr_idx),
    .i_wr_data(i_wr_data)
`endif
  );

  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    idx_d     = idx_q;
    o_ready_d = o_ready_q;
    o_valid_d = o_valid_q;
    o_index_d = o_index_q;
    o_hit_d   = o_hit_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid && o_ready_q) begin
          value_d   = i_value;
          idx_d     = 2'd0;
          o_ready_d = 1'b0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        // Scanning upward means the lowest matching index wins on duplicates.
        if (rd_data == value_q) begin
          o_index_d = idx_q;
          o_hit_d   = 1'b1;
          o_valid_d = 1'b1;
          state_d   = DONE;
        end else if (idx_q == LAST_IDX) begin
          o_index_d = MISS_IDX;
          o_hit_d   = 1'b0;
          o_valid_d = 1'b1;
          state_d   = DONE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      DONE: begin
        if (i_ready) begin
          o_valid_d = 1'b0;
          o_ready_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        o_valid_d = 1'b0;
        o_ready_d = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      value_q   <= '0;
      idx_q     <= 2'd0;
      o_ready_q <= 1'b1;
      o_valid_q <= 1'b0;
      o_index_q <= 2'd0;
      o_hit_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      idx_q     <= idx_d;
      o_ready_q <= o_ready_d;
      o_valid_q <= o_valid_d;
      o_index_q <= o_index_d;
      o_hit_q   <= o_hit_d;
    end
  end

  assign o_ready = o_ready_q;
  assign o_valid = o_valid_q;
  assign o_index = o_index_q;
  assign o_hit   = o_hit_q;

endmodule
